// File: rtl/pdm_sample_sequencer_if.sv
// ---------------------------------------------------------------------------
// pdm_sample_sequencer_if
// Producer-to-sequencer sample handshake (valid/ready).
//   sample_in         signed 8-bit audio sample offered by the producer
//   sample_valid_in   producer has a sample on sample_in
//   sample_ready_out  sequencer FIFO can accept a sample this cycle
// master = producer side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface pdm_sample_sequencer_if;

    logic signed [7:0] sample_in;
    logic              sample_valid_in;
    logic              sample_ready_out;

    modport master (
        output sample_in,
        output sample_valid_in,
        input  sample_ready_out
    );

    modport slave (
        input  sample_in,
        input  sample_valid_in,
        output sample_ready_out
    );

endinterface

// File: rtl/pdm_sample_sequencer.sv
// ---------------------------------------------------------------------------
// pdm_sample_sequencer
// Paces audio samples into the 8-bit signed PDM modulator. Samples arrive
// through a valid/ready handshake into a FIFO; the block generates the
// modulator tick strobe and presents one FIFO sample on level_out every
// TICKS_PER_SAMPLE ticks. Handles priming, underrun recovery and
// enable/disable sequencing.
//
// Ports:
//   clk_in          system clock
//   rst_in          synchronous active-high reset
//   enable_in       run request; low = stop, flush FIFO, output silence
//   sample_if       slave side of the sample handshake (sample_in,
//                   sample_valid_in, registered sample_ready_out)
//   tick_out        one-cycle strobe to pdm tick_in
//   level_out       signed level to pdm level_in
//   underrun_out    one-cycle pulse when a sample is due but FIFO is empty
//   fifo_count_out  current FIFO occupancy, 0..FIFO_DEPTH
//   running_out     high while in RUN
//
// Optional feature macro: PDM_SEQ_SLEW_EN
//   Defined: popped samples load a target register and level_out steps
//   toward it by 1 LSB per tick. Undefined: level_out loads the popped
//   sample directly.
// ---------------------------------------------------------------------------
module pdm_sample_sequencer #(
    parameter int unsigned TICK_DIV         = 4,
    parameter int unsigned TICKS_PER_SAMPLE = 32,
    parameter int unsigned FIFO_DEPTH       = 16,
    parameter int unsigned PRIME_LEVEL      = 8
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          enable_in,
    pdm_sample_sequencer_if.slave         sample_if,
    output logic                          tick_out,
    output logic signed [7:0]             level_out,
    output logic                          underrun_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
    output logic                          running_out
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned DIV_W  = $clog2(TICK_DIV);
    localparam int unsigned SCNT_W = $clog2(TICKS_PER_SAMPLE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t state_q;
    state_t state_nxt;

    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_nxt;
    logic [SCNT_W-1:0] scnt_q;
    logic [SCNT_W-1:0] scnt_nxt;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_nxt;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_nxt;
    logic signed [7:0] mem_q [FIFO_DEPTH];
    logic signed [7:0] level_q;
    logic signed [7:0] level_nxt;
    logic              tick_q;
    logic              tick_nxt;
    logic              underrun_q;
    logic              ready_q;
    logic              ready_nxt;
    logic              running_q;

`ifdef PDM_SEQ_SLEW_EN
    logic signed [7:0] target_q;
    logic signed [7:0] target_nxt;
`endif

    logic              push_c;
    logic              pop_slot_c;
    logic              pop_c;
    logic              underrun_c;
    logic              pop_ahead_c;
    logic signed [7:0] head_c;

    // Handshake and pop/underrun decode for the current cycle
    assign head_c     = mem_q[rd_ptr_q];
    assign push_c     = enable_in && sample_if.sample_valid_in && ready_q;
    assign pop_slot_c = enable_in && (state_q == ST_RUN) && tick_q && (scnt_q == '0);
    assign pop_c      = pop_slot_c && (count_q != '0);
    assign underrun_c = pop_slot_c && (count_q == '0);

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic; disable overrides every state
    always_comb begin
        state_nxt = state_q;
        if (!enable_in) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_nxt = ST_PRIME;
                ST_PRIME: if (count_q >= CNT_W'(PRIME_LEVEL)) state_nxt = ST_RUN;
                ST_RUN:   if (underrun_c) state_nxt = ST_PRIME;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Datapath next values: FIFO pointers/count, tick divider, sample counter, level
    always_comb begin
        count_nxt   = count_q;
        wr_ptr_nxt  = wr_ptr_q;
        rd_ptr_nxt  = rd_ptr_q;
        div_nxt     = '0;
        scnt_nxt    = '0;
        level_nxt   = level_q;
`ifdef PDM_SEQ_SLEW_EN
        target_nxt  = target_q;
`endif
        tick_nxt    = 1'b0;
        pop_ahead_c = 1'b0;
        ready_nxt   = 1'b1;

        if (!enable_in) begin
            // Flush wins over any push; output goes silent immediately
            count_nxt  = '0;
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            level_nxt  = '0;
`ifdef PDM_SEQ_SLEW_EN
            target_nxt = '0;
`endif
        end else begin
            if (push_c) wr_ptr_nxt = wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_nxt = rd_ptr_q + PTR_W'(1);

            case ({push_c, pop_c})
                2'b10:   count_nxt = count_q + CNT_W'(1);
                2'b01:   count_nxt = count_q - CNT_W'(1);
                default: count_nxt = count_q;
            endcase

            // Divider free-runs through PRIME and RUN; cleared on the way out of IDLE
            if (state_q != ST_IDLE) begin
                div_nxt = (div_q == DIV_W'(TICK_DIV - 1)) ? '0 : div_q + DIV_W'(1);
            end

            // Sample counter only advances in RUN; underrun restarts it at 0
            if ((state_q == ST_RUN) && !underrun_c) begin
                scnt_nxt = scnt_q;
                if (tick_q) begin
                    scnt_nxt = (scnt_q == SCNT_W'(TICKS_PER_SAMPLE - 1))
                             ? '0 : scnt_q + SCNT_W'(1);
                end
            end

`ifdef PDM_SEQ_SLEW_EN
            if (pop_c) begin
                target_nxt = head_c;
            end else if (underrun_c) begin
                target_nxt = '0;
            end
            // Single-LSB step toward the (possibly just updated) target per tick
            if (tick_q) begin
                if (level_q < target_nxt) begin
                    level_nxt = level_q + 8'sd1;
                end else if (level_q > target_nxt) begin
                    level_nxt = level_q - 8'sd1;
                end
            end
`else
            if (pop_c) begin
                level_nxt = head_c;
            end else if (underrun_c) begin
                level_nxt = '0;
            end
`endif
        end

        tick_nxt = (state_nxt != ST_IDLE) && (div_nxt == DIV_W'(TICK_DIV - 1));

        // Ready stays high at full when the coming cycle pops, so push+pop at full is accepted
        pop_ahead_c = (state_nxt == ST_RUN) && tick_nxt && (scnt_nxt == '0) && (count_nxt != '0);
        ready_nxt   = (count_nxt != CNT_W'(FIFO_DEPTH)) || pop_ahead_c;
    end

    // Datapath and output registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            div_q      <= '0;
            scnt_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            level_q    <= '0;
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
            ready_q    <= 1'b1;
            running_q  <= 1'b0;
`ifdef PDM_SEQ_SLEW_EN
            target_q   <= '0;
`endif
        end else begin
            div_q      <= div_nxt;
            scnt_q     <= scnt_nxt;
            wr_ptr_q   <= wr_ptr_nxt;
            rd_ptr_q   <= rd_ptr_nxt;
            count_q    <= count_nxt;
            level_q    <= level_nxt;
            tick_q     <= tick_nxt;
            underrun_q <= underrun_c;
            ready_q    <= ready_nxt;
            running_q  <= (state_nxt == ST_RUN);
`ifdef PDM_SEQ_SLEW_EN
            target_q   <= target_nxt;
`endif
        end
    end

    // Sample storage; contents need no reset since count gates every read
    always_ff @(posedge clk_in) begin
        if (!rst_in && push_c) begin
            mem_q[wr_ptr_q] <= sample_if.sample_in;
        end
    end

    assign sample_if.sample_ready_out = ready_q;
    assign tick_out                   = tick_q;
    assign level_out                  = level_q;
    assign underrun_out               = underrun_q;
    assign fifo_count_out             = count_q;
    assign running_out                = running_q;

endmodule

// File: tb/tb_pdm_sample_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pdm_sample_sequencer
// Directed bench for pdm_sample_sequencer. DUT A uses default parameters
// (reset, priming, paced playback, underrun, disable); DUT B uses
// PRIME_LEVEL=16 (full FIFO, backpressure, push+pop at full). With
// PDM_SEQ_SLEW_EN defined, DUT C exercises level slewing.
// ---------------------------------------------------------------------------
module tb_pdm_sample_sequencer;

    logic clk_in = 1'b0;
    logic rst_in;
    always #5 clk_in = ~clk_in;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // DUT A: defaults
    logic              en_a;
    logic              tick_a;
    logic signed [7:0] lvl_a;
    logic              und_a;
    logic [4:0]        cnt_a;
    logic              run_a;
    pdm_sample_sequencer_if if_a ();

    pdm_sample_sequencer u_dut_a (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .enable_in      (en_a),
        .sample_if      (if_a),
        .tick_out       (tick_a),
        .level_out      (lvl_a),
        .underrun_out   (und_a),
        .fifo_count_out (cnt_a),
        .running_out    (run_a)
    );

    // DUT B: must fill completely before running
    logic              en_b;
    logic              tick_b;
    logic signed [7:0] lvl_b;
    logic              und_b;
    logic [4:0]        cnt_b;
    logic              run_b;
    pdm_sample_sequencer_if if_b ();

    pdm_sample_sequencer #(.PRIME_LEVEL(16)) u_dut_b (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .enable_in      (en_b),
        .sample_if      (if_b),
        .tick_out       (tick_b),
        .level_out      (lvl_b),
        .underrun_out   (und_b),
        .fifo_count_out (cnt_b),
        .running_out    (run_b)
    );

`ifdef PDM_SEQ_SLEW_EN
    // DUT C: long sample period so a full-scale slew completes between pops
    logic              en_c;
    logic              tick_c;
    logic signed [7:0] lvl_c;
    logic              und_c;
    logic [2:0]        cnt_c;
    logic              run_c;
    pdm_sample_sequencer_if if_c ();

    pdm_sample_sequencer #(
        .TICK_DIV(2), .TICKS_PER_SAMPLE(256), .FIFO_DEPTH(4), .PRIME_LEVEL(2)
    ) u_dut_c (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .enable_in      (en_c),
        .sample_if      (if_c),
        .tick_out       (tick_c),
        .level_out      (lvl_c),
        .underrun_out   (und_c),
        .fifo_count_out (cnt_c),
        .running_out    (run_c)
    );
`endif

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clock edges, then settle 1 time unit past the last edge
    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic wait_run_tick_a(input string tag, input int limit);
        int n;
        n = 0;
        while (!(run_a && tick_a) && (n < limit)) begin
            step(1);
            n++;
        end
        check(tag, 32'(n < limit), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic quiet_bad;
`ifdef PDM_SEQ_SLEW_EN
        int n;
`endif
        rst_in = 1'b1;
        en_a = 1'b0; if_a.sample_valid_in = 1'b0; if_a.sample_in = '0;
        en_b = 1'b0; if_b.sample_valid_in = 1'b0; if_b.sample_in = '0;
`ifdef PDM_SEQ_SLEW_EN
        en_c = 1'b0; if_c.sample_valid_in = 1'b0; if_c.sample_in = '0;
`endif
        step(2);

        // Reset values
        check("rst_level",    lvl_a, 0);
        check("rst_tick",     tick_a, 0);
        check("rst_ready",    if_a.sample_ready_out, 1);
        check("rst_count",    cnt_a, 0);
        check("rst_running",  run_a, 0);
        check("rst_underrun", und_a, 0);

        // Prime with 10..80; ticks start TICK_DIV cycles after leaving IDLE
        rst_in = 1'b0;
        en_a   = 1'b1;
        if_a.sample_valid_in = 1'b1;
        if_a.sample_in       = 8'sd10;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            check($sformatf("prime_count_%0d", i), cnt_a, i);
            check($sformatf("prime_tick_%0d", i), tick_a, 32'((i % 4) == 0));
            if (i < 8) if_a.sample_in = 8'(10 * (i + 1));
            else       if_a.sample_valid_in = 1'b0;
        end
        check("prime_not_running", run_a, 0);
        step(1);
        check("run_entered", run_a, 1);
        check("run_count8",  cnt_a, 8);
        step(3);
        check("first_run_tick", tick_a, 1);
        check("level_before_pop", lvl_a, 0);
        step(1);
`ifndef PDM_SEQ_SLEW_EN
        check("level_first_pop", lvl_a, 10);
`endif
        check("count_after_pop", cnt_a, 7);

        // One pop every 32 ticks = 128 clocks
        for (int k = 1; k <= 7; k++) begin
            step(127);
`ifndef PDM_SEQ_SLEW_EN
            check($sformatf("level_hold_%0d", k), lvl_a, 10 * k);
`endif
            step(1);
`ifndef PDM_SEQ_SLEW_EN
            check($sformatf("level_pop_%0d", k), lvl_a, 10 * (k + 1));
`endif
        end
        check("drained", cnt_a, 0);

        // Next pop slot finds the FIFO empty
        step(127);
        check("ur_slot_tick", tick_a, 1);
        check("ur_not_yet",   und_a, 0);
        step(1);
        check("ur_pulse",   und_a, 1);
`ifndef PDM_SEQ_SLEW_EN
        check("ur_level",   lvl_a, 0);
`endif
        check("ur_running", run_a, 0);
        step(1);
        check("ur_pulse_end", und_a, 0);

        // Refill -1..-8 and resume
        if_a.sample_valid_in = 1'b1;
        if_a.sample_in       = -8'sd1;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if_a.sample_in = 8'(-(i + 1));
        end
        if_a.sample_valid_in = 1'b0;
        check("refill_count", cnt_a, 8);
        check("refill_prime", run_a, 0);
        wait_run_tick_a("resume_wait", 200);
        step(1);
`ifndef PDM_SEQ_SLEW_EN
        check("resume_level", lvl_a, -1);
`endif
        step(128);
        step(128);
`ifndef PDM_SEQ_SLEW_EN
        check("resume_level3", lvl_a, -3);
`endif
        check("count5", cnt_a, 5);

        // Disable mid-RUN with 5 queued
        en_a = 1'b0;
        step(1);
        check("dis_count",   cnt_a, 0);
        check("dis_level",   lvl_a, 0);
        check("dis_running", run_a, 0);
        check("dis_tick",    tick_a, 0);
        check("dis_ready",   if_a.sample_ready_out, 1);
        quiet_bad = 1'b0;
        if_a.sample_valid_in = 1'b1;
        if_a.sample_in       = 8'sd55;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (tick_a || (cnt_a != 0) || (lvl_a != 0)) quiet_bad = 1'b1;
        end
        if_a.sample_valid_in = 1'b0;
        check("dis_quiet", quiet_bad, 0);

        // Full FIFO and backpressure on DUT B
        en_b = 1'b1;
        if_b.sample_valid_in = 1'b1;
        if_b.sample_in       = 8'sd1;
        for (int i = 1; i <= 16; i++) begin
            step(1);
            check($sformatf("fill_count_%0d", i), cnt_b, i);
            if_b.sample_in = (i < 16) ? 8'(i + 1) : 8'sd99;
        end
        check("full_ready", if_b.sample_ready_out, 0);
        step(1);
        check("full_extra_ignored", cnt_b, 16);
        check("full_running", run_b, 1);
        step(3);
        check("full_pop_tick", tick_b, 1);
        check("full_ready_on_pop", if_b.sample_ready_out, 1);
        check("full_count_pre", cnt_b, 16);
        step(1);
        check("full_pushpop_count", cnt_b, 16);
`ifndef PDM_SEQ_SLEW_EN
        check("full_level", lvl_b, 1);
`endif
        check("full_ready_after", if_b.sample_ready_out, 0);
        if_b.sample_valid_in = 1'b0;
        en_b = 1'b0;
        step(1);
        check("full_flush", cnt_b, 0);

`ifdef PDM_SEQ_SLEW_EN
        // Slew: 127 then -128 from level 0
        en_c = 1'b1;
        if_c.sample_valid_in = 1'b1;
        if_c.sample_in       = 8'sd127;
        step(1);
        if_c.sample_in = -8'sd128;
        step(1);
        if_c.sample_valid_in = 1'b0;
        n = 0;
        while (!(run_c && tick_c) && (n < 100)) begin
            step(1);
            n++;
        end
        check("slew_wait", 32'(n < 100), 1);
        step(1);
        check("slew_step1", lvl_c, 1);
        step(252);
        check("slew_reach_127", lvl_c, 127);
        step(4);
        check("slew_hold_127", lvl_c, 127);
        step(256);
        check("slew_down_1", lvl_c, 126);
        step(20);
        check("slew_down_11", lvl_c, 116);
        en_c = 1'b0;
        step(1);
        check("slew_idle_zero", lvl_c, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
